// File: rtl/axil_initiator.sv
// axil_initiator: single-outstanding AXI4-Lite manager.
// Bridges a valid/ready request/response port onto AW/W/B and AR/R.
module axil_initiator #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [1:0]              m_bresp,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WB   = 3'd2,
        S_RA   = 3'd3,
        S_RD   = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;
    logic                    w_accept;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_b_hs;
    logic                    w_r_hs;
    logic                    w_unused;

    // Only bit 1 of BRESP/RRESP distinguishes an error response.
    assign w_unused = ^{m_bresp[0], m_rresp[0]};

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_aw_hs  = (r_state == S_WR) && !r_aw_done && m_awready;
    assign w_w_hs   = (r_state == S_WR) && !r_w_done && m_wready;
    assign w_b_hs   = (r_state == S_WB) && m_bvalid;
    assign w_r_hs   = (r_state == S_RD) && m_rvalid;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and channel control decode.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = req_we ? S_WR : S_RA;
            end
            S_WR: begin
                m_awvalid = !r_aw_done;
                m_wvalid  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
                    w_next = S_WB;
            end
            S_WB: begin
                m_bready = 1'b1;
                if (m_bvalid) w_next = S_RESP;
            end
            S_RA: begin
                m_arvalid = 1'b1;
                if (m_arready) w_next = S_RD;
            end
            S_RD: begin
                m_rready = 1'b1;
                if (m_rvalid) w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture, channel progress flags and response data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (w_b_hs) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_rdata   <= '0;
                r_err     <= m_bresp[1];
            end
            if (w_r_hs) begin
                r_rdata <= m_rdata;
                r_err   <= m_rresp[1];
            end
        end
    end

    assign m_awaddr   = r_addr;
    assign m_araddr   = r_addr;
    assign m_wdata    = r_wdata;
    assign m_wstrb    = r_wstrb;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_axil_initiator.sv
// tb_axil_initiator: table, directed and random checks of axil_initiator
// against a RAM responder and a request-level memory model.
module tb_axil_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_awaddr;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    logic [1:0]  m_bresp = 2'b00;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_araddr;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = 2'b00;

    axil_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rresp(m_rresp)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // responder configuration (set by the test while the DUT is idle)
    int cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;
    logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;

    // responder state and observation counters
    logic [31:0] rmem [16];
    logic [31:0] ref_mem [16];
    logic aw_got = 0, w_got = 0, ar_got = 0;
    logic aw_pend = 0, w_pend = 0, b_pend = 0, ar_pend = 0, r_pend = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic p_awv = 0, p_wv = 0, p_arv = 0;
    logic [31:0] p_awa = 0, p_wd = 0, p_ara = 0;
    logic [3:0] p_ws = 0;
    logic [31:0] last_awaddr = 0, last_araddr = 0, c_wdata = 0;
    logic [3:0] c_wstrb = 0;
    int vio = 0, aw_hi_n = 0, w_hi_n = 0, b_hs_n = 0, resp_n = 0;

    // AXI4-Lite RAM responder with programmable stalls, driven mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_awready = 0; m_wready = 0; m_arready = 0;
            m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rresp = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            p_awv = 0; p_wv = 0; p_arv = 0;
        end else begin
            if (p_awv && !aw_pend && (!m_awvalid || m_awaddr !== p_awa)) vio++;
            if (p_wv && !w_pend && (!m_wvalid || m_wdata !== p_wd || m_wstrb !== p_ws)) vio++;
            if (p_arv && !ar_pend && (!m_arvalid || m_araddr !== p_ara)) vio++;
            if (m_awvalid) aw_hi_n++;
            if (m_wvalid) w_hi_n++;
            if (resp_valid && resp_ready) resp_n++;
            if (aw_pend) begin aw_got = 1; last_awaddr = p_awa; end
            if (w_pend) begin w_got = 1; c_wdata = p_wd; c_wstrb = p_ws; end
            if (b_pend) begin
                m_bvalid = 0; aw_got = 0; w_got = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; b_hs_n++;
            end
            if (ar_pend) begin ar_got = 1; last_araddr = p_ara; end
            if (r_pend) begin m_rvalid = 0; ar_got = 0; ar_cnt = 0; r_cnt = 0; end
            m_awready = m_awvalid && !aw_got && (aw_cnt >= cfg_aw);
            if (m_awvalid && !aw_got && !m_awready) aw_cnt++;
            m_wready = m_wvalid && !w_got && (w_cnt >= cfg_w);
            if (m_wvalid && !w_got && !m_wready) w_cnt++;
            m_arready = m_arvalid && !ar_got && (ar_cnt >= cfg_ar);
            if (m_arvalid && !ar_got && !m_arready) ar_cnt++;
            if (aw_got && w_got && !m_bvalid) begin
                if (b_cnt >= cfg_b) begin
                    m_bvalid = 1; m_bresp = cfg_bresp;
                    if (cfg_bresp == 2'b00)
                        for (int i = 0; i < 4; i++)
                            if (c_wstrb[i])
                                rmem[last_awaddr[5:2]][8*i +: 8] = c_wdata[8*i +: 8];
                end else b_cnt++;
            end
            if (ar_got && !m_rvalid) begin
                if (r_cnt >= cfg_r) begin
                    m_rvalid = 1; m_rresp = cfg_rresp;
                    m_rdata = rmem[last_araddr[5:2]];
                end else r_cnt++;
            end
            aw_pend = m_awvalid && m_awready;
            w_pend  = m_wvalid && m_wready;
            ar_pend = m_arvalid && m_arready;
            b_pend  = m_bvalid && m_bready;
            r_pend  = m_rvalid && m_rready;
            p_awv = m_awvalid; p_awa = m_awaddr;
            p_wv = m_wvalid; p_wd = m_wdata; p_ws = m_wstrb;
            p_arv = m_arvalid; p_ara = m_araddr;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic ref_write(input logic [31:0] a, d, input logic [3:0] s);
        for (int i = 0; i < 4; i++)
            if (s[i]) ref_mem[a[5:2]][8*i +: 8] = d[8*i +: 8];
    endtask

    // One request/response round trip, called and returning at a negedge.
    task automatic do_req(input logic we, input logic [31:0] a, d, input logic [3:0] s,
                          input int hold, input logic [31:0] er, input logic ee,
                          input string nm, output int lat);
        int n;
        req_we = we; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        check({nm, "_req_ready"}, req_ready, 1);
        @(negedge clk);
        req_valid = 0; req_addr = ~a; req_wdata = ~d;
        n = 0;
        while (!resp_valid && n < 200) begin @(negedge clk); n++; end
        lat = n;
        check({nm, "_resp_valid"}, resp_valid, 1);
        for (int i = 0; i < hold; i++) begin
            check({nm, "_hold_rdata"}, resp_rdata, er);
            check({nm, "_hold_valid"}, resp_valid, 1);
            check({nm, "_hold_req_ready"}, req_ready, 0);
            @(negedge clk);
        end
        check({nm, "_rdata"}, resp_rdata, er);
        check({nm, "_err"}, resp_err, ee);
        check({nm, "_hs_req_ready"}, req_ready, 0);
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        check({nm, "_after_valid"}, resp_valid, 0);
        check({nm, "_after_req_ready"}, req_ready, 1);
        check({nm, "_axi_addr"}, we ? last_awaddr : last_araddr, a);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw, w, b, ar, r;
        logic [1:0]  bresp, rresp;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input logic we, input logic [31:0] a, d, input logic [3:0] s,
                                input int aw, w, b, ar, r, input logic [1:0] br, rr,
                                input int hold, input logic [31:0] er, input logic ee,
                                input int lat);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.strb = s;
        v.aw = aw; v.w = w; v.b = b; v.ar = ar; v.r = r;
        v.bresp = br; v.rresp = rr; v.hold = hold;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
        return v;
    endfunction

    task automatic set_cfg(input int aw, w, b, ar, r, input logic [1:0] br, rr);
        cfg_aw = aw; cfg_w = w; cfg_b = b; cfg_ar = ar; cfg_r = r;
        cfg_bresp = br; cfg_rresp = rr;
    endtask

    initial begin
        int lat, a0, w0, b0, r0, n, idx, hold;
        logic seen, we, ee;
        logic [31:0] a, d, er;
        logic [3:0] s;
        logic [1:0] br, rr;
        for (int i = 0; i < 16; i++) begin rmem[i] = '0; ref_mem[i] = '0; end

        tbl[0]  = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 0,0,0,0,0, 2'b00,2'b00, 0, 32'h0, 0, 2);
        tbl[1]  = mk(0, 32'h10, 32'h0,        4'h0, 0,0,0,0,0, 2'b00,2'b00, 0, 32'hDEADBEEF, 0, 2);
        tbl[2]  = mk(1, 32'h10, 32'h00001234, 4'h3, 0,0,0,0,0, 2'b00,2'b00, 0, 32'h0, 0, -1);
        tbl[3]  = mk(0, 32'h10, 32'h0,        4'h0, 0,0,0,0,0, 2'b00,2'b00, 5, 32'hDEAD1234, 0, -1);
        tbl[4]  = mk(1, 32'h20, 32'hCAFEF00D, 4'hF, 0,0,0,0,0, 2'b10,2'b00, 0, 32'h0, 1, -1);
        tbl[5]  = mk(0, 32'h10, 32'h0,        4'h0, 0,0,0,0,0, 2'b00,2'b11, 0, 32'hDEAD1234, 1, -1);
        tbl[6]  = mk(1, 32'h24, 32'hA5A5A5A5, 4'hF, 1,2,1,0,0, 2'b00,2'b00, 0, 32'h0, 0, -1);
        tbl[7]  = mk(0, 32'h24, 32'h0,        4'h0, 0,0,0,2,3, 2'b00,2'b00, 1, 32'hA5A5A5A5, 0, -1);
        tbl[8]  = mk(1, 32'h24, 32'h0000FF00, 4'h2, 0,3,0,0,0, 2'b00,2'b00, 0, 32'h0, 0, -1);
        tbl[9]  = mk(0, 32'h24, 32'h0,        4'h0, 0,0,0,0,0, 2'b00,2'b00, 0, 32'hA5A5FFA5, 0, -1);
        tbl[10] = mk(0, 32'h20, 32'h0,        4'h0, 0,0,2,0,1, 2'b00,2'b01, 2, 32'h0, 0, -1);

        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, resp_valid}, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            set_cfg(tbl[i].aw, tbl[i].w, tbl[i].b, tbl[i].ar, tbl[i].r,
                    tbl[i].bresp, tbl[i].rresp);
            do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].strb, tbl[i].hold,
                   tbl[i].exp_rdata, tbl[i].exp_err, $sformatf("vec%0d", i), lat);
            if (tbl[i].exp_lat >= 0)
                check($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
            if (tbl[i].we && tbl[i].bresp == 2'b00)
                ref_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb);
        end

        set_cfg(3, 0, 0, 0, 0, 2'b00, 2'b00);
        a0 = aw_hi_n; w0 = w_hi_n; b0 = b_hs_n; r0 = resp_n;
        do_req(1, 32'h30, 32'h11223344, 4'hF, 0, 32'h0, 0, "awstall", lat);
        ref_write(32'h30, 32'h11223344, 4'hF);
        check("awstall_awvalid_cycles", aw_hi_n - a0, 4);
        check("awstall_wvalid_cycles", w_hi_n - w0, 1);
        check("awstall_b_count", b_hs_n - b0, 1);
        check("awstall_resp_count", resp_n - r0, 1);

        set_cfg(0, 0, 0, 0, 20, 2'b00, 2'b00);
        req_we = 0; req_addr = 32'h10; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        n = 0;
        while (!m_rready && n < 50) begin @(negedge clk); n++; end
        check("rstrd_in_rd", m_rready, 1);
        rst_n = 0;
        @(negedge clk);
        check("rstrd_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, resp_valid}, 0);
        check("rstrd_req_ready", req_ready, 1);
        seen = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) seen = 1;
            @(negedge clk);
        end
        check("rstrd_no_resp", seen, 0);
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00);
        do_req(0, 32'h10, 32'h0, 4'h0, 0, ref_mem[4], 0, "rstrd_after", lat);

        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 15);
            a = $urandom();
            a[5:0] = {idx[3:0], 2'b00};
            d = $urandom();
            s = 4'($urandom_range(0, 15));
            br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            hold = $urandom_range(0, 3);
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), br, rr);
            er = we ? 32'h0 : ref_mem[idx];
            ee = we ? br[1] : rr[1];
            do_req(we, a, d, s, hold, er, ee, $sformatf("rnd%0d", t), lat);
            if (we && br == 2'b00) ref_write(a, d, s);
        end

        check("valid_stability_violations", vio, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
